// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester offers a byte and watches ready, busy and the completion pulses.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output busy,
      output done,
      output err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send,
// clocks one command byte out on device clock edges and checks the ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES  = 5000,
   parameter int SETUP_CYCLES    = 16,
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic           clk,
   input  logic           rst,
   ps2_host_tx_if.slave   bus,
   input  logic           kclk_i,
   input  logic           kdata_i,
   output logic           kclk_oe,
   output logic           kdata_oe
);

   localparam int CMAX =
      (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
      ((TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES) :
      ((INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES);
   localparam int CW = $clog2(CMAX + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t          state;
   state_t          nxt;

   logic [1:0]      raw;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      filt;
   logic [DW-1:0]   dcnt [2];
   logic            kclk_q;
   logic            kclk_f;
   logic            kdata_f;
   logic            kclk_fall;

   logic [7:0]      data;
   logic            parity;
   logic [3:0]      idx;
   logic [CW-1:0]   cnt;
   logic [9:0]      oe_bits;

   logic            accept;
   logic            in_wd;
   logic            inh_hit;
   logic            setup_hit;
   logic            wd_hit;
   logic            fin_ok;
   logic            fin_bad;

   assign raw     = {kdata_i, kclk_i};
   assign kclk_f  = filt[0];
   assign kdata_f = filt[1];

   // two-flop synchronizers for both lines, idle-high after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // debounce: a line only changes after a full run of differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt    <= 2'b11;
         dcnt[0] <= '0;
         dcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               filt[i] <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   // previous filtered clock, for the falling-edge strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kclk_q <= 1'b1;
      end else begin
         kclk_q <= kclk_f;
      end
   end

   assign kclk_fall = kclk_q & ~kclk_f;

   assign accept    = bus.tx_valid & bus.tx_ready;
   assign in_wd     = (state == SEND) ||
                      (state == ACK)  ||
                      (state == WAIT_IDLE);
   assign inh_hit   = (cnt == CW'(INHIBIT_CYCLES - 1));
   assign setup_hit = (cnt == CW'(SETUP_CYCLES - 1));
   assign wd_hit    = in_wd && !kclk_fall &&
                      (cnt == CW'(TIMEOUT_CYCLES - 1));

   // line drive per bit index: data bits, parity, then release for stop
   assign oe_bits = {1'b0, ~parity, ~data};

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // next-state logic and end-of-frame events
   always_comb begin
      nxt     = state;
      fin_ok  = 1'b0;
      fin_bad = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               nxt = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_hit) begin
               nxt = REQ;
            end
         end
         REQ: begin
            if (setup_hit) begin
               nxt = SEND;
            end
         end
         SEND: begin
            if (wd_hit) begin
               nxt     = IDLE;
               fin_bad = 1'b1;
            end else if (kclk_fall && idx == 4'd9) begin
               nxt = ACK;
            end
         end
         ACK: begin
            if (wd_hit) begin
               nxt     = IDLE;
               fin_bad = 1'b1;
            end else if (kclk_fall) begin
               if (kdata_f) begin
                  nxt     = IDLE;
                  fin_bad = 1'b1;
               end else begin
                  nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (kclk_f && kdata_f) begin
               nxt    = IDLE;
               fin_ok = 1'b1;
            end else if (wd_hit) begin
               nxt     = IDLE;
               fin_bad = 1'b1;
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   // state-decoded outputs; kclk is only pulled while the host owns it
   always_comb begin
      kclk_oe      = 1'b0;
      bus.busy     = 1'b1;
      bus.tx_ready = 1'b0;
      unique case (state)
         IDLE: begin
            bus.busy     = 1'b0;
            bus.tx_ready = 1'b1;
         end
         INHIBIT, REQ: begin
            kclk_oe = 1'b1;
         end
         default: begin
            kclk_oe = 1'b0;
         end
      endcase
   end

   // phase timer / watchdog, shared since the phases never overlap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (state != nxt) begin
         cnt <= '0;
      end else if (in_wd && kclk_fall) begin
         cnt <= '0;
      end else if (state != IDLE) begin
         cnt <= cnt + 1'b1;
      end
   end

   // frame datapath: byte capture, bit shifting and data-line drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data     <= '0;
         parity   <= 1'b0;
         idx      <= '0;
         kdata_oe <= 1'b0;
      end else begin
         if (accept) begin
            data   <= bus.tx_data;
            parity <= ~^bus.tx_data;
            idx    <= '0;
         end
         if (nxt == IDLE) begin
            kdata_oe <= 1'b0;
         end else if (state == INHIBIT && nxt == REQ) begin
            kdata_oe <= 1'b1;
         end else if (state == SEND && kclk_fall) begin
            kdata_oe <= oe_bits[idx];
            idx      <= idx + 1'b1;
         end
      end
   end

   // one-cycle completion pulses, aligned with the return to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
      end else begin
         bus.done <= fin_ok;
         bus.err  <= fin_bad;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, behavioural keyboard
// and a scoreboard of expected frame outcomes.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int SET = 4;
   localparam int DEB = 4;
   localparam int TO  = 300;
   localparam int H   = 15;

   localparam int K_ERR  = 1;
   localparam int K_DONE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic kclk_i;
   logic kdata_i;
   logic kclk_oe;
   logic kdata_oe;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;

   ps2_host_tx_if bus ();

   assign kclk_i  = ~(kclk_oe | dev_clk_low);
   assign kdata_i = ~(kdata_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES  (INH),
      .SETUP_CYCLES    (SET),
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .kclk_i   (kclk_i),
      .kdata_i  (kdata_i),
      .kclk_oe  (kclk_oe),
      .kdata_oe (kdata_oe)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] byt;
      int         kind;
   } exp_t;

   exp_t       q[$];
   logic [7:0] rx_byte = '0;
   logic       rx_par  = 1'b0;

   logic clk_oe_q = 1'b0;
   logic pulse_q  = 1'b0;
   int   rel_cyc  = 0;
   int   err_cyc  = 0;
   int   inh_run  = 0;
   int   inh_len  = 0;
   int   pulses   = 0;

   // bus-timing monitor: release time, error time, inhibit length
   always @(negedge clk) begin
      if (clk_oe_q && !kclk_oe) rel_cyc = cyc;
      clk_oe_q = kclk_oe;
      if (kclk_oe && !kdata_oe) begin
         inh_run++;
      end else if (inh_run != 0) begin
         inh_len = inh_run;
         inh_run = 0;
      end
      if (bus.err === 1'b1) err_cyc = cyc;
   end

   // scoreboard: every done/err pulse pops one expected outcome
   always @(negedge clk) begin
      logic p;
      exp_t e;
      p = (bus.done === 1'b1) || (bus.err === 1'b1);
      if (!rst && p) begin
         pulses++;
         check("one_cycle", 32'(pulse_q), 32'd0);
         if (q.size() == 0) begin
            check("spurious", 32'({bus.done, bus.err}), 32'd0);
         end else begin
            e = q.pop_front();
            check("kind", 32'({bus.done, bus.err}), e.kind);
            check("ready_at_end", 32'(bus.tx_ready), 32'd1);
            if (e.kind == K_ERR)
               check("released", 32'({kclk_oe, kdata_oe}), 32'd0);
            else
               check("byte", 32'(rx_byte), 32'(e.byt));
         end
      end
      pulse_q = p && !rst;
   end

   // keyboard model. mode 0 ack, 1 nack, 2 silent,
   // 3 stop after four clocks, 4 ack with short kclk glitches
   task automatic device(input int mode);
      int n;
      logic [9:0] bits;
      n = 0;
      while (kclk_i !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      while (!(kclk_i === 1'b1 && kdata_i === 1'b0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         check("req_seen", 32'd0, 32'd1);
         return;
      end
      if (mode == 2) return;
      repeat (H) @(negedge clk);
      bits = '0;
      for (int i = 0; i < 10; i++) begin
         if (mode == 3 && i == 4) return;
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
         bits[i] = kdata_i;
         if (mode == 4) begin
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (DEB - 2) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H - 3 - (DEB - 2)) @(negedge clk);
         end else begin
            repeat (2) @(negedge clk);
            if (i == 9 && mode != 1) dev_dat_low = 1'b1;
            repeat (H - 2) @(negedge clk);
         end
         if (i == 9 && mode == 4) dev_dat_low = 1'b1;
      end
      if (mode == 4) repeat (H) @(negedge clk);
      rx_byte = bits[7:0];
      rx_par  = bits[8];
      check("parity", 32'(bits[8]), 32'(~^bits[7:0]));
      check("stop", 32'(bits[9]), 32'd1);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
      dev_dat_low = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int kind,
                       input bit hold);
      exp_t e;
      @(negedge clk);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      if (kind != 0) begin
         e.byt  = b;
         e.kind = kind;
         q.push_back(e);
      end
      @(negedge clk);
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      if (hold) begin
         bus.tx_data = ~b;
         repeat (30) @(negedge clk);
         check("ready_while_busy", 32'(bus.tx_ready), 32'd0);
      end
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
   endtask

   task automatic wait_q();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("result_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int p0;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_kclk_oe", 32'(kclk_oe), 32'd0);
      check("rst_kdata_oe", 32'(kdata_oe), 32'd0);
      check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready", 32'(bus.tx_ready), 32'd1);
      rst = 1'b0;
      repeat (DEB + 5) @(negedge clk);

      fork
         device(0);
         send(8'hED, K_DONE, 1'b1);
      join
      wait_q();
      check("rx_ed", 32'(rx_byte), 32'hED);
      check("par_ed", 32'(rx_par), 32'd1);
      check("inhibit_len", 32'(inh_len >= INH), 32'd1);

      fork
         device(0);
         send(8'hF4, K_DONE, 1'b0);
      join
      wait_q();
      check("par_f4", 32'(rx_par), 32'd0);

      fork
         device(1);
         send(8'h55, K_ERR, 1'b0);
      join
      wait_q();

      fork
         device(2);
         send(8'hAA, K_ERR, 1'b0);
      join
      wait_q();
      check("wd_time", 32'(err_cyc - rel_cyc), 32'(TO));

      p0 = pulses;
      fork
         device(3);
         send(8'h12, 0, 1'b0);
      join
      check("mid_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_oe", 32'({kclk_oe, kdata_oe}), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (DEB + 20) @(negedge clk);
      check("arst_no_pulse", 32'(pulses - p0), 32'd0);

      fork
         device(0);
         send(8'hFF, K_DONE, 1'b0);
      join
      wait_q();
      check("rx_ff", 32'(rx_byte), 32'hFF);

      fork
         device(4);
         send(8'h3C, K_DONE, 1'b0);
      join
      wait_q();
      check("rx_glitch", 32'(rx_byte), 32'h3C);

      check("q_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
